// File: rtl/fractal_pkg.sv
// Shared types and helpers for the fractal pixel stream receiver.
//   MAX_ITER    : iteration count that marks "inside the set" (drawn black)
//   rgb_t       : packed {r, g, b} 8-bit-per-channel pixel
//   beat_t      : one buffered input beat {sof, eol, data}
//   iter_to_rgb : colormap from iteration count to rgb_t
package fractal_pkg;

  localparam logic [7:0] MAX_ITER = 8'd255;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } beat_t;

  // R ramps with i, G ramps twice as fast and clips at 255, B falls off.
  function automatic rgb_t iter_to_rgb(input logic [7:0] i);
    rgb_t       c;
    logic [8:0] dbl;
    dbl = {i, 1'b0};
    c   = '0;
    if (i != MAX_ITER) begin
      c.r = i;
      c.g = dbl[8] ? 8'hFF : dbl[7:0];
      c.b = 8'hFF - i;
    end
    return c;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en_i      : write request; taken when not full, or when full and a
//                  read happens in the same cycle
//   wr_data_i    : element to write
//   rd_en_i      : pop the head element (ignored when empty)
//   rd_data_o    : head element, valid whenever !empty_o
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
module stream_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_en_i,
  input  T     wr_data_i,
  input  logic rd_en_i,
  output T     rd_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  T            mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_wr, do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot the write lands in.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/fractal_stream_receiver.sv
// Consumer end of the fractal pixel stream.
// Locks onto the first frame_start, checks frame geometry, buffers beats in a
// FIFO and emits colormapped pixels on an AXI4-Stream video master.
//   clk, reset            : clock, asynchronous active-high reset
//   width_in, height_in   : frame geometry; must be nonzero and held stable
//                           whenever reset is low
//   s_data/s_frame_start/s_line_end/s_valid : generator beat, no backpressure
//   m_tdata/m_tuser/m_tlast/m_tvalid/m_tready : video master ({R,G,B})
//   clear_status          : one-cycle pulse clearing sticky flags and drop_count
//   overflow, sof_error, eol_error : sticky status
//   drop_count            : beats lost to a full FIFO, saturating
//   frame_count           : completed frames, wrapping
//
// Handshake: a beat moves on m_* at a rising edge where m_tvalid && m_tready.
// Once m_tvalid is high, m_tdata/m_tuser/m_tlast hold until that transfer.
module fractal_stream_receiver
  import fractal_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            width_in,
  input  logic [15:0]            height_in,
  input  logic [7:0]             s_data,
  input  logic                   s_frame_start,
  input  logic                   s_line_end,
  input  logic                   s_valid,
  output logic [23:0]            m_tdata,
  output logic                   m_tuser,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  input  logic                   clear_status,
  output logic                   overflow,
  output logic                   sof_error,
  output logic                   eol_error,
  output logic [15:0]            drop_count,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  // ---------------- state ----------------
  logic                   locked_q, locked_d;
  logic [15:0]            in_x_q, in_x_d;
  logic [15:0]            in_y_q, in_y_d;
  logic                   overflow_q, overflow_d;
  logic                   sof_err_q, sof_err_d;
  logic                   eol_err_q, eol_err_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   tvalid_q, tvalid_d;
  rgb_t                   tdata_q, tdata_d;
  logic                   tuser_q, tuser_d;
  logic                   tlast_q, tlast_d;

  // ---------------- FIFO ----------------
  beat_t fifo_wdata, fifo_head;
  logic  fifo_full, fifo_empty;
  logic  accept, wr_en, rd_en, drop;
  logic  at_last_x, at_last_y, exp_sof;
  logic  sof_bad, eol_bad;

  // The beat carrying frame_start is taken even before lock is set.
  assign accept    = s_valid && (locked_q || s_frame_start);
  assign rd_en     = !fifo_empty && (!tvalid_q || m_tready);
  assign wr_en     = accept && (!fifo_full || rd_en);
  assign drop      = accept && fifo_full && !rd_en;

  assign at_last_x = (in_x_q == width_in - 16'd1);
  assign at_last_y = (in_y_q == height_in - 16'd1);
  assign exp_sof   = (in_x_q == 16'd0) && (in_y_q == 16'd0);
  assign sof_bad   = accept && (s_frame_start != exp_sof);
  assign eol_bad   = accept && (s_line_end != at_last_x);

  assign fifo_wdata = '{sof: s_frame_start, eol: s_line_end, data: s_data};

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (beat_t)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (wr_en),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (rd_en),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // ---------------- geometry tracking ----------------
  always_comb begin
    locked_d    = locked_q | (s_valid && s_frame_start);
    in_x_d      = in_x_q;
    in_y_d      = in_y_q;
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      if (s_frame_start) begin
        // Resync: this beat is pixel (0,0), so the next one is x=1.
        in_x_d = 16'd1;
        in_y_d = 16'd0;
      end else if (s_line_end || at_last_x) begin
        in_x_d = 16'd0;
        in_y_d = at_last_y ? 16'd0 : in_y_q + 16'd1;
      end else begin
        in_x_d = in_x_q + 16'd1;
      end
      if (s_line_end && at_last_y) frame_cnt_d = frame_cnt_q + FRAME_ONE;
    end
  end

  // ---------------- sticky status ----------------
  // A new event in the same cycle as clear_status leaves the flag set.
  always_comb begin
    overflow_d = (overflow_q & ~clear_status) | drop;
    sof_err_d  = (sof_err_q & ~clear_status) | sof_bad;
    eol_err_d  = (eol_err_q & ~clear_status) | eol_bad;
    drop_cnt_d = clear_status ? 16'd0 : drop_cnt_q;
    if (drop) begin
      if (clear_status)              drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // ---------------- output register ----------------
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    if (rd_en) begin
      tvalid_d = 1'b1;
      tdata_d  = iter_to_rgb(fifo_head.data);
      tuser_d  = fifo_head.sof;
      tlast_d  = fifo_head.eol;
    end else if (m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q    <= 1'b0;
      in_x_q      <= '0;
      in_y_q      <= '0;
      overflow_q  <= 1'b0;
      sof_err_q   <= 1'b0;
      eol_err_q   <= 1'b0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      locked_q    <= locked_d;
      in_x_q      <= in_x_d;
      in_y_q      <= in_y_d;
      overflow_q  <= overflow_d;
      sof_err_q   <= sof_err_d;
      eol_err_q   <= eol_err_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
    end
  end

  assign m_tdata     = tdata_q;
  assign m_tuser     = tuser_q;
  assign m_tlast     = tlast_q;
  assign m_tvalid    = tvalid_q;
  assign overflow    = overflow_q;
  assign sof_error   = sof_err_q;
  assign eol_error   = eol_err_q;
  assign drop_count  = drop_cnt_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_fractal_stream_receiver.sv
// Directed bench for fractal_stream_receiver with a scoreboard on the
// AXI4-Stream output.
module tb_fractal_stream_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] width_in, height_in;
  logic [7:0]  s_data;
  logic        s_frame_start, s_line_end, s_valid;
  logic [23:0] m_tdata;
  logic        m_tuser, m_tlast, m_tvalid, m_tready;
  logic        clear_status;
  logic        overflow, sof_error, eol_error;
  logic [15:0] drop_count;
  logic [15:0] frame_count;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [25:0] exp_q[$];       // {tuser, tlast, tdata}
  logic        sb_en     = 1'b0;
  logic        saw_valid = 1'b0;
  logic [23:0] ramp_rgb [18];  // colormap of data 0..17, hand-computed

  fractal_stream_receiver #(.FIFO_DEPTH(16), .FRAME_CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .width_in      (width_in),
    .height_in     (height_in),
    .s_data        (s_data),
    .s_frame_start (s_frame_start),
    .s_line_end    (s_line_end),
    .s_valid       (s_valid),
    .m_tdata       (m_tdata),
    .m_tuser       (m_tuser),
    .m_tlast       (m_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .clear_status  (clear_status),
    .overflow      (overflow),
    .sof_error     (sof_error),
    .eol_error     (eol_error),
    .drop_count    (drop_count),
    .frame_count   (frame_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!reset) assert (width_in != 16'd0 && height_in != 16'd0)
      else $error("zero frame geometry while out of reset");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (m_tvalid) saw_valid = 1'b1;
    if (sb_en && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'(exp_q.size()), 32'd1);
      else check("out_beat", {6'd0, m_tuser, m_tlast, m_tdata}, {6'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [15:0] w, input logic [15:0] h);
    reset         = 1'b1;
    width_in      = w;
    height_in     = h;
    s_valid       = 1'b0;
    s_frame_start = 1'b0;
    s_line_end    = 1'b0;
    s_data        = 8'd0;
    clear_status  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input logic eol);
    s_valid       = 1'b1;
    s_data        = d;
    s_frame_start = sof;
    s_line_end    = eol;
    @(posedge clk);
    #1;
    s_valid       = 1'b0;
    s_frame_start = 1'b0;
    s_line_end    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    @(posedge clk);
    #1 clear_status = 1'b0;
  endtask

  // 4x3 frame, data 0..11, SOF on beat 0, EOL on beats 3/7/11.
  task automatic clean_frame();
    for (int k = 0; k < 12; k++) begin
      exp_q.push_back({(k == 0), (k % 4 == 3), ramp_rgb[k]});
      send(8'(k), (k == 0), (k % 4 == 3));
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag, input logic ov, input logic se, input logic ee);
    check({tag, "_overflow"}, 32'(overflow), 32'(ov));
    check({tag, "_sof_error"}, 32'(sof_error), 32'(se));
    check({tag, "_eol_error"}, 32'(eol_error), 32'(ee));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ramp_rgb = '{24'h0000FF, 24'h0102FE, 24'h0204FD, 24'h0306FC, 24'h0408FB, 24'h050AFA,
                 24'h060CF9, 24'h070EF8, 24'h0810F7, 24'h0912F6, 24'h0A14F5, 24'h0B16F4,
                 24'h0C18F3, 24'h0D1AF2, 24'h0E1CF1, 24'h0F1EF0, 24'h1020EF, 24'h1122EE};
    m_tready = 1'b1;

    // Reset state
    do_reset(16'd4, 16'd3);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);

    // Clean 4x3 stream
    sb_en = 1'b1;
    clean_frame();
    drain("clean_drain");
    check("clean_frame_count", 32'(frame_count), 32'd1);
    check_flags("clean", 1'b0, 1'b0, 1'b0);
    check("clean_tvalid_idle", 32'(m_tvalid), 32'd0);

    // Colormap corners
    do_reset(16'd4, 16'd3);
    exp_q.push_back({1'b1, 1'b0, 24'h0000FF});
    exp_q.push_back({1'b0, 1'b0, 24'h64C89B});
    exp_q.push_back({1'b0, 1'b0, 24'hC8FF37});
    exp_q.push_back({1'b0, 1'b1, 24'h000000});
    send(8'd0, 1'b1, 1'b0);
    send(8'd100, 1'b0, 1'b0);
    send(8'd200, 1'b0, 1'b0);
    send(8'd255, 1'b0, 1'b1);
    drain("cmap_drain");

    // Backpressure: 20 beats into a stalled sink, 4 wide x 8 high
    do_reset(16'd4, 16'd8);
    m_tready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      send(8'(k), (k == 1), (k % 4 == 0));
      if (k >= 2) begin
        check("bp_hold_tdata", 32'(m_tdata), 32'h0102FE);
        check("bp_hold_tvalid", 32'(m_tvalid), 32'd1);
      end
    end
    check_flags("bp", 1'b1, 1'b0, 1'b0);
    check("bp_drop_count", 32'(drop_count), 32'd3);
    pulse_clear();
    check("bp_clr_overflow", 32'(overflow), 32'd0);
    check("bp_clr_drop_count", 32'(drop_count), 32'd0);
    for (int k = 1; k <= 17; k++) exp_q.push_back({(k == 1), (k % 4 == 0), ramp_rgb[k]});
    m_tready = 1'b1;
    drain("bp_drain");
    check("bp_tvalid_idle", 32'(m_tvalid), 32'd0);

    // Pre-lock garbage then a clean frame
    do_reset(16'd4, 16'd3);
    for (int k = 0; k < 5; k++) send(8'h55, 1'b0, (k == 3));
    clean_frame();
    drain("prelock_drain");
    check("prelock_drop_count", 32'(drop_count), 32'd0);
    check_flags("prelock", 1'b0, 1'b0, 1'b0);
    check("prelock_frame_count", 32'(frame_count), 32'd1);

    // Sync faults, width 4
    sb_en = 1'b0;
    do_reset(16'd4, 16'd3);
    send(8'd0, 1'b1, 1'b0);            // (0,0)
    send(8'd1, 1'b0, 1'b0);            // (1,0)
    send(8'd2, 1'b0, 1'b1);            // (2,0) early EOL
    check_flags("sync_eol", 1'b0, 1'b0, 1'b1);
    send(8'd3, 1'b0, 1'b0);            // (0,1)
    check("sync_next_line_ok", 32'(sof_error), 32'd0);
    send(8'd4, 1'b1, 1'b0);            // (1,1) stray SOF, resync to (1,0)
    check_flags("sync_sof", 1'b0, 1'b1, 1'b1);
    pulse_clear();
    check_flags("sync_clr", 1'b0, 1'b0, 1'b0);
    send(8'd5, 1'b0, 1'b0);            // (1,0)
    send(8'd6, 1'b0, 1'b0);            // (2,0)
    send(8'd7, 1'b0, 1'b1);            // (3,0)
    for (int k = 0; k < 8; k++) send(8'd8, 1'b0, (k % 4 == 3));   // lines 1, 2
    send(8'd9, 1'b1, 1'b0);            // next frame at (0,0)
    check_flags("sync_resync", 1'b0, 1'b0, 1'b0);
    check("sync_frame_count", 32'(frame_count), 32'd1);
    clear_status = 1'b1;               // same edge as a bad EOL at (1,0)
    send(8'd10, 1'b0, 1'b1);
    clear_status = 1'b0;
    check("clear_vs_event", 32'(eol_error), 32'd1);

    // Asynchronous reset mid-frame with 8 beats buffered
    do_reset(16'd4, 16'd3);
    m_tready = 1'b0;
    for (int k = 0; k < 9; k++) send(8'(k), (k == 0), (k % 4 == 3));
    check("mid_tvalid_before", 32'(m_tvalid), 32'd1);
    #3 reset = 1'b1;
    #1 check("mid_async_tvalid", 32'(m_tvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_tready  = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 3; k++) send(8'h33, 1'b0, 1'b0);
    idle(6);
    check("mid_idle_until_sof", 32'(saw_valid), 32'd0);
    sb_en = 1'b1;
    clean_frame();
    drain("mid_relock_drain");
    check("mid_frame_count", 32'(frame_count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
